// File: rtl/addsub_rr_arbiter_if.sv
// Request/result bundle between datapath clients and the shared add/sub arbiter.
// Requester i owns bit i of the per-requester vectors and bits [i*N +: N] of the operand buses.
interface addsub_rr_arbiter_if #(
    parameter int N    = 8,
    parameter int R    = 4,
    parameter int ID_W = 2
);
    logic [R-1:0]   req_valid;
    logic [R-1:0]   req_ready;
    logic [R*N-1:0] req_a;
    logic [R*N-1:0] req_b;
    logic [R-1:0]   req_sub;
    logic           res_valid;
    logic           res_ready;
    logic [N-1:0]   res_y;
    logic           res_carry;
    logic           res_overflow;
    logic [ID_W-1:0] res_id;

    modport master (
        output req_valid, req_a, req_b, req_sub, res_ready,
        input  req_ready, res_valid, res_y, res_carry, res_overflow, res_id
    );

    modport slave (
        input  req_valid, req_a, req_b, req_sub, res_ready,
        output req_ready, res_valid, res_y, res_carry, res_overflow, res_id
    );
endinterface

// File: rtl/addsub_rr_arbiter.sv
// Round-robin arbiter sharing one N-bit adder/subtractor among R requesters;
// the winning result is registered and returned tagged with the requester ID.
module adder_subtractor #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic [N-1:0] y,
    output logic         carry_out,
    output logic         overflow
);
    logic [N-1:0] b_eff;
    logic [N:0]   sum;

    assign b_eff     = sub ? ~b : b;
    assign sum       = {1'b0, a} + {1'b0, b_eff} + {{N{1'b0}}, sub};
    assign y         = sum[N-1:0];
    assign carry_out = sum[N];
    assign overflow  = (a[N-1] == b_eff[N-1]) && (sum[N-1] != a[N-1]);
endmodule

module addsub_rr_arbiter #(
    parameter int N    = 8,
    parameter int R    = 4,
    parameter int ID_W = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    addsub_rr_arbiter_if.slave bus
);
    localparam int PTR_W = (R > 1) ? $clog2(R) : 1;
    localparam int CW    = $clog2(2 * R);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t            state_reg, state_next;
    logic [PTR_W-1:0]  ptr_reg, ptr_next;
    logic [N-1:0]      res_y_reg;
    logic              res_carry_reg;
    logic              res_overflow_reg;
    logic [ID_W-1:0]   res_id_reg;

    logic [N-1:0]      a_arr [R];
    logic [N-1:0]      b_arr [R];
    logic              sub_arr [R];
    logic [R-1:0]      ready_vec;

    logic              res_valid;
    logic              accept;
    logic [(1<<CW)-1:0] valid_pad;
    logic [CW-1:0]     cand;
    logic [CW-1:0]     cand_sel;
    logic              found;
    logic [PTR_W-1:0]  grant_idx;
    logic              grant_valid;

    logic [N-1:0]      alu_y;
    logic              alu_carry;
    logic              alu_overflow;

    assign res_valid = (state_reg == FULL);
    assign accept    = !res_valid || bus.res_ready;

    genvar gi;
    generate
        for (gi = 0; gi < R; gi++) begin : g_req
            assign a_arr[gi]     = bus.req_a[gi*N +: N];
            assign b_arr[gi]     = bus.req_b[gi*N +: N];
            assign sub_arr[gi]   = bus.req_sub[gi];
            assign ready_vec[gi] = grant_valid && (grant_idx == PTR_W'(gi));
        end
    endgenerate

    // Search a doubled copy of req_valid from ptr upward so the rotation needs no modulo
    // inside the loop; iterating from the far end lets the nearest hit win.
    always_comb begin
        valid_pad            = '0;
        valid_pad[2*R-1:0]   = {bus.req_valid, bus.req_valid};
        found                = 1'b0;
        cand                 = '0;
        cand_sel             = '0;
        for (int k = R - 1; k >= 0; k--) begin
            cand = CW'(ptr_reg) + CW'(k);
            if (valid_pad[cand]) begin
                found    = 1'b1;
                cand_sel = cand;
            end
        end
        grant_idx = (cand_sel >= CW'(R)) ? PTR_W'(cand_sel - CW'(R)) : PTR_W'(cand_sel);
    end

    // No grant may escape while reset is asserted, even though the FSM already reads EMPTY.
    assign grant_valid = found && accept && rst_n;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            EMPTY:   if (grant_valid) state_next = FULL;
            FULL:    if (bus.res_ready && !grant_valid) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
    end

    always_comb begin
        ptr_next = ptr_reg;
        if (grant_valid) begin
            ptr_next = (grant_idx == PTR_W'(R - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    adder_subtractor #(.N(N)) u_alu (
        .a         (a_arr[grant_idx]),
        .b         (b_arr[grant_idx]),
        .sub       (sub_arr[grant_idx]),
        .y         (alu_y),
        .carry_out (alu_carry),
        .overflow  (alu_overflow)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= EMPTY;
            ptr_reg   <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
        end
    end

    // Result fields only change on a grant, so a plain drain leaves the last values visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_y_reg        <= '0;
            res_carry_reg    <= 1'b0;
            res_overflow_reg <= 1'b0;
            res_id_reg       <= '0;
        end else if (grant_valid) begin
            res_y_reg        <= alu_y;
            res_carry_reg    <= alu_carry;
            res_overflow_reg <= alu_overflow;
            res_id_reg       <= ID_W'(grant_idx);
        end
    end

    assign bus.req_ready    = ready_vec;
    assign bus.res_valid    = res_valid;
    assign bus.res_y        = res_y_reg;
    assign bus.res_carry    = res_carry_reg;
    assign bus.res_overflow = res_overflow_reg;
    assign bus.res_id       = res_id_reg;
endmodule

// File: tb/tb_addsub_rr_arbiter.sv
// Bench for addsub_rr_arbiter: directed scenarios plus random traffic, checked against
// an arithmetic/round-robin reference model kept in plain integers.
module tb_addsub_rr_arbiter;
    localparam int N    = 8;
    localparam int R    = 4;
    localparam int ID_W = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    addsub_rr_arbiter_if #(.N(N), .R(R), .ID_W(ID_W)) bus ();

    addsub_rr_arbiter #(.N(N), .R(R), .ID_W(ID_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Requester-side state: a request stays up until it is granted.
    logic       q_valid [R];
    logic [7:0] q_a     [R];
    logic [7:0] q_b     [R];
    logic       q_sub   [R];
    logic       res_ready_drv;

    // Reference model state.
    int m_ptr;
    bit m_valid;
    int m_y, m_c, m_o, m_id;
    int last_g;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic drive();
        for (int i = 0; i < R; i++) begin
            bus.req_valid[i]       = q_valid[i];
            bus.req_a[i*N +: N]    = q_a[i];
            bus.req_b[i*N +: N]    = q_b[i];
            bus.req_sub[i]         = q_sub[i];
        end
        bus.res_ready = res_ready_drv;
    endtask

    function automatic int exp_grant();
        if (m_valid && !res_ready_drv) return -1;
        for (int k = 0; k < R; k++) begin
            int idx;
            idx = (m_ptr + k) % R;
            if (q_valid[idx]) return idx;
        end
        return -1;
    endfunction

    // Signed/unsigned integer arithmetic, independent of the carry-chain formulation.
    task automatic ref_op(input int a, input int b, input bit sub,
                          output int y, output int c, output int o);
        int sa, sb, r;
        sa = (a > 127) ? a - 256 : a;
        sb = (b > 127) ? b - 256 : b;
        r  = sub ? sa - sb : sa + sb;
        o  = (r > 127 || r < -128) ? 1 : 0;
        c  = sub ? ((a >= b) ? 1 : 0) : ((a + b > 255) ? 1 : 0);
        y  = (sub ? a - b : a + b) & 255;
    endtask

    task automatic set_req(input int i, input int a, input int b, input bit sub);
        q_valid[i] = 1'b1;
        q_a[i]     = 8'(a);
        q_b[i]     = 8'(b);
        q_sub[i]   = sub;
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < R; i++) q_valid[i] = 1'b0;
    endtask

    task automatic model_reset();
        m_ptr = 0; m_valid = 1'b0; m_y = 0; m_c = 0; m_o = 0; m_id = 0;
    endtask

    // One clock: drive, check the combinational grant, clock, update model, check results.
    task automatic cycle(input string tag);
        int g;
        logic [31:0] exp_ready;
        drive();
        #1;
        g = exp_grant();
        exp_ready = (g < 0) ? 32'd0 : (32'd1 << g);
        check({tag, ".ready"}, 32'(bus.req_ready), exp_ready);
        @(posedge clk);
        #1;
        last_g = g;
        if (g >= 0) begin
            ref_op(int'(q_a[g]), int'(q_b[g]), q_sub[g], m_y, m_c, m_o);
            m_valid = 1'b1;
            m_id    = g;
            m_ptr   = (g + 1) % R;
            q_valid[g] = 1'b0;
            $display("txn %s id=%0d a=%02h b=%02h sub=%0d -> y=%02h c=%0d o=%0d",
                     tag, g, q_a[g], q_b[g], q_sub[g], bus.res_y, bus.res_carry, bus.res_overflow);
        end else if (m_valid && res_ready_drv) begin
            m_valid = 1'b0;
        end
        check({tag, ".valid"}, 32'(bus.res_valid),    32'(m_valid));
        check({tag, ".y"},     32'(bus.res_y),        m_y);
        check({tag, ".carry"}, 32'(bus.res_carry),    m_c);
        check({tag, ".ovf"},   32'(bus.res_overflow), m_o);
        check({tag, ".id"},    32'(bus.res_id),       m_id);
    endtask

    initial begin
        int ids [5];
        for (int i = 0; i < R; i++) begin
            q_valid[i] = 1'b0; q_a[i] = '0; q_b[i] = '0; q_sub[i] = 1'b0;
        end
        res_ready_drv = 1'b1;
        model_reset();
        last_g = -1;

        // Reset: outputs zero and no grant even with a request pending.
        set_req(0, 8'h05, 8'h03, 1'b1);
        drive();
        @(posedge clk); @(posedge clk); #1;
        check("rst.valid", 32'(bus.res_valid), 32'd0);
        check("rst.y",     32'(bus.res_y),     32'd0);
        check("rst.id",    32'(bus.res_id),    32'd0);
        check("rst.ready", 32'(bus.req_ready), 32'd0);
        rst_n = 1'b1;

        // Single request 5-3.
        cycle("single");
        check("single.y_const", 32'(bus.res_y), 32'h02);
        check("single.c_const", 32'(bus.res_carry), 32'd1);
        cycle("single_drain");

        // Overflow / wrap corners.
        set_req(1, 8'h7F, 8'h01, 1'b0);
        cycle("ovf_7f_add");
        check("ovf1.y_const", 32'(bus.res_y), 32'h80);
        check("ovf1.o_const", 32'(bus.res_overflow), 32'd1);
        set_req(2, 8'hFF, 8'h01, 1'b0);
        cycle("wrap_ff_add");
        check("wrap.y_const", 32'(bus.res_y), 32'h00);
        check("wrap.c_const", 32'(bus.res_carry), 32'd1);
        set_req(3, 8'h80, 8'h01, 1'b1);
        cycle("ovf_80_sub");
        check("ovf3.y_const", 32'(bus.res_y), 32'h7F);
        check("ovf3.o_const", 32'(bus.res_overflow), 32'd1);
        cycle("ovf_drain");

        // Round-robin with all four requesting continuously.
        for (int i = 0; i < R; i++) set_req(i, $urandom_range(0, 255), $urandom_range(0, 255), 1'($urandom));
        for (int s = 0; s < 5; s++) begin
            cycle("rr");
            ids[s] = last_g;
            if (last_g >= 0) set_req(last_g, $urandom_range(0, 255), $urandom_range(0, 255), 1'($urandom));
        end
        check("rr.seq0", 32'(ids[0]), 32'd0);
        check("rr.seq1", 32'(ids[1]), 32'd1);
        check("rr.seq2", 32'(ids[2]), 32'd2);
        check("rr.seq3", 32'(ids[3]), 32'd3);
        check("rr.seq4", 32'(ids[4]), 32'd0);
        clear_reqs();
        cycle("rr_drain");

        // Backpressure: 3-5 held for three cycles, then a pending request goes the same cycle.
        set_req(1, 8'h03, 8'h05, 1'b1);
        cycle("bp_load");
        res_ready_drv = 1'b0;
        set_req(2, 8'h10, 8'h20, 1'b0);
        for (int s = 0; s < 3; s++) begin
            cycle("bp_stall");
            check("bp.y_const",  32'(bus.res_y),     32'hFE);
            check("bp.c_const",  32'(bus.res_carry), 32'd0);
            check("bp.id_const", 32'(bus.res_id),    32'd1);
        end
        res_ready_drv = 1'b1;
        cycle("bp_release");
        check("bp.next_id", 32'(bus.res_id), 32'd2);
        check("bp.next_y",  32'(bus.res_y),  32'h30);
        clear_reqs();
        cycle("bp_drain");

        // Pointer skip: bring ptr to 1, then requesters 2 and 0.
        set_req(0, 8'h01, 8'h01, 1'b0);
        cycle("skip_setup");
        set_req(2, 8'h22, 8'h02, 1'b0);
        set_req(0, 8'h44, 8'h04, 1'b1);
        cycle("skip_a");
        check("skip.first", 32'(bus.res_id), 32'd2);
        cycle("skip_b");
        check("skip.second", 32'(bus.res_id), 32'd0);
        set_req(0, 8'h01, 8'h02, 1'b0);
        set_req(1, 8'h03, 8'h04, 1'b0);
        cycle("skip_ptr");
        check("skip.ptr_is_1", 32'(bus.res_id), 32'd1);
        clear_reqs();
        cycle("skip_drain");

        // Random traffic with random backpressure.
        for (int c = 0; c < 300; c++) begin
            res_ready_drv = ($urandom_range(0, 9) < 7);
            for (int i = 0; i < R; i++) begin
                if (!q_valid[i] && $urandom_range(0, 2) == 0)
                    set_req(i, $urandom_range(0, 255), $urandom_range(0, 255), 1'($urandom));
            end
            cycle("rand");
        end
        clear_reqs();
        res_ready_drv = 1'b1;
        cycle("rand_drain");
        cycle("rand_idle");

        // Reset mid-stall: pointer left at 3 beforehand so a missed pointer reset shows up.
        set_req(2, 8'h09, 8'h04, 1'b1);
        cycle("rs_load");
        res_ready_drv = 1'b0;
        set_req(0, 8'h11, 8'h22, 1'b0);
        cycle("rs_stall");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rs.valid", 32'(bus.res_valid),    32'd0);
        check("rs.y",     32'(bus.res_y),        32'd0);
        check("rs.carry", 32'(bus.res_carry),    32'd0);
        check("rs.ovf",   32'(bus.res_overflow), 32'd0);
        check("rs.id",    32'(bus.res_id),       32'd0);
        check("rs.ready", 32'(bus.req_ready),    32'd0);
        res_ready_drv = 1'b1;
        drive();
        @(posedge clk); #1;
        check("rs.hold_ready", 32'(bus.req_ready), 32'd0);
        check("rs.hold_valid", 32'(bus.res_valid), 32'd0);
        rst_n = 1'b1;
        clear_reqs();
        set_req(1, 8'h05, 8'h05, 1'b1);
        set_req(3, 8'h06, 8'h01, 1'b0);
        cycle("rs_after");
        check("rs.first_from_0", 32'(bus.res_id), 32'd1);
        clear_reqs();
        cycle("rs_drain");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/addsub_rr_arbiter.md
Name: addsub_rr_arbiter

Overview:
- Shares one `adder_subtractor` instance (N-bit add/sub with carry_out and signed overflow) between R requesters.
- Each requester presents operands and an op select over a valid/ready handshake.
- A round-robin arbiter grants one request per cycle. The result is registered and returned on a single output channel tagged with the winning requester's ID, with valid/ready backpressure.
- Sits between several datapath clients and the shared adder/subtractor.

Parameters:
- N, 8, operand/result width; passed to the internal `adder_subtractor`.
- R, 4, number of requesters (2..16).
- ID_W, 2, width of result ID; must satisfy R <= 2**ID_W.

Ports:
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  R  per-requester request valid
- req_ready  output  R  per-requester accept; one-hot or zero
- req_a  input  R*N  operand A; requester i at bits [i*N +: N]
- req_b  input  R*N  operand B, same packing
- req_sub  input  R  per-requester op: 0 = a+b, 1 = a-b
- res_valid  output  1  registered result valid
- res_ready  input  1  downstream accepts result
- res_y  output  N  result, a±b mod 2^N
- res_carry  output  1  adder carry_out; for subtract, 1 = no borrow (a >= b unsigned)
- res_overflow  output  1  signed two's-complement overflow
- res_id  output  ID_W  index of requester that produced the result

Behaviour:
- Reset (rst_n low, asynchronous): res_valid=0, res_y=0, res_carry=0, res_overflow=0, res_id=0, rr pointer=0. req_ready=0 while in reset.
- accept = !res_valid || res_ready. This is combinational; the output register is free or draining this cycle.
- Grant: when accept=1, the first i with req_valid[i]=1 is chosen, searching ptr, ptr+1, …, ptr+R-1 mod R.
  - req_ready[grant]=1; all other req_ready bits are 0.
  - No valid request → req_ready all 0.
- req_ready may depend combinationally on req_valid and res_ready. Requesters must not make req_valid depend on req_ready.
- Transfer on a requester: req_valid[i] && req_ready[i] at a rising edge. On that edge:
  - The selected a, b, sub drive the `adder_subtractor`.
  - Its y, carry_out and overflow load into res_y, res_carry and res_overflow.
  - res_id <= i, res_valid <= 1.
  - ptr <= (i+1) mod R.
- Latency: result visible one cycle after the request transfer.
- Throughput: one op per cycle when res_ready is held at 1. Back-to-back means draining the old result and loading the new one on the same edge.
- Stall: res_valid=1 and res_ready=0 → all res_* outputs hold stable, req_ready=0, ptr unchanged.
- Drain with no new grant: res_valid && res_ready and no request → res_valid <= 0. res_y, res_carry, res_overflow and res_id keep their last values.
- Fairness: a continuously requesting client is granted within R grants.
- ptr advances only on a grant; idle cycles leave it unchanged.
- A requester must hold its request valid and stable until it is accepted. The arbiter does not latch operands before the grant.
- Two-state FSM implied by res_valid:
  - EMPTY → FULL on grant.
  - FULL → FULL on res_ready with a grant.
  - FULL → EMPTY on res_ready with no grant.
  - FULL → FULL on !res_ready.
- Reset mid-operation: a pending result is discarded (res_valid=0 immediately) and ptr returns to 0. No grant is issued while rst_n is low.
- Arithmetic: y = a + (sub ? ~b : b) + sub, computed in N+1 bits. carry = bit N. overflow = the signs of a and the effective b match and differ from y[N-1].

Test Plan:
- Single request: req0 a=0x05 b=0x03 sub=1 → next cycle res_valid=1, y=0x02, carry=1, overflow=0, id=0.
- Overflow/wrap cases:
  - req1 a=0x7F b=0x01 add → y=0x80, carry=0, ovf=1.
  - req2 a=0xFF b=0x01 add → y=0x00, carry=1, ovf=0.
  - req3 a=0x80 b=0x01 sub → y=0x7F, carry=1, ovf=1.
- Round-robin: all 4 requesters valid continuously, res_ready=1, ptr=0 after reset → res_id sequence 0,1,2,3,0 on consecutive cycles; exactly one req_ready per cycle.
- Backpressure: res_ready=0 for 3 cycles with result 0x03-0x05 held → y=0xFE, carry=0, id stable; req_ready=0 throughout. Raise res_ready → next pending request granted the same cycle.
- Pointer skip: only req2 and req0 valid, ptr=1 → grant 2 then 0; ptr=1 after the second grant.
- Reset mid-stall: res_valid=1, rst_n pulsed low asynchronously between edges → res_valid=0 and outputs zero immediately. After release, first grant starts search at 0.
